// File: rtl/nibble_sequencer.sv
// Nibble sequencer: fetches 12-bit instructions from an external program ROM,
// drives an external 4-bit ALU and hands results to a ready/valid output port.
module nibble_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_addr,
  output logic        rom_en,
  input  logic [11:0] rom_data,
  output logic [2:0]  alu_opcode,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic [3:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halted
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, OUTWAIT} state_t;

  localparam logic [2:0] OP_OUT = 3'd0;
  localparam logic [2:0] OP_CMP = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_JC  = 3'd6;
  localparam logic [2:0] OP_JZ  = 3'd7;

  state_t      state, state_nx;
  logic [7:0]  pc, pc_nx, pc_inc, target;
  logic [3:0]  acc, acc_nx, nor_res, out_data_nx;
  logic [11:0] ir, ir_nx;
  logic        carry, carry_nx, zero, zero_nx;
  logic        out_valid_nx, halted_nx;
  logic        ir_unused;

  assign pc_inc    = pc + 8'd1;
  assign target    = ir[7:0];
  assign nor_res   = ~(acc | ir[3:0]);
  assign ir_unused = ir[8];

  assign rom_addr   = pc;
  assign rom_en     = (state == FETCH);
  assign alu_opcode = (state == EXEC) ? ir[11:9] : 3'b000;
  assign alu_a      = acc;
  assign alu_b      = ir[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= 8'd0;
      acc       <= 4'd0;
      ir        <= 12'd0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 4'd0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      acc       <= acc_nx;
      ir        <= ir_nx;
      carry     <= carry_nx;
      zero      <= zero_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      halted    <= halted_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    acc_nx       = acc;
    ir_nx        = ir;
    carry_nx     = carry;
    zero_nx      = zero;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    halted_nx    = halted;

    case (state)
      IDLE: begin
        if (start) begin
          pc_nx     = 8'd0;
          halted_nx = 1'b0;
          state_nx  = FETCH;
        end
      end
      FETCH: state_nx = DECODE;
      DECODE: begin
        ir_nx    = rom_data;
        state_nx = EXEC;
      end
      EXEC: begin
        pc_nx    = pc_inc;
        state_nx = FETCH;
        case (ir[11:9])
          OP_OUT: begin
            out_data_nx  = acc;
            out_valid_nx = 1'b1;
            pc_nx        = pc;
            state_nx     = OUTWAIT;
          end
          OP_CMP: begin
            carry_nx = alu_carry;
            zero_nx  = alu_zero;
          end
          OP_LD: acc_nx = ir[3:0];
          OP_ADD: begin
            acc_nx   = alu_out;
            carry_nx = alu_carry;
            zero_nx  = alu_zero;
          end
          OP_NOR: begin
            acc_nx   = nor_res;
            zero_nx  = (nor_res == 4'd0);
            carry_nx = 1'b0;
          end
          // A jump onto itself can never make progress, so it parks the sequencer.
          OP_JMP: begin
            pc_nx = target;
            if (target == pc) begin
              halted_nx = 1'b1;
              state_nx  = IDLE;
            end
          end
          OP_JC: if (carry) pc_nx = target;
          OP_JZ: if (zero) pc_nx = target;
        endcase
      end
      OUTWAIT: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          pc_nx        = pc_inc;
          state_nx     = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibble_sequencer.sv
// Bench for nibble_sequencer: ROM and ALU models, a vector table, directed
// multi-cycle sequences and random programs checked against an ISA-level model.
module tb_nibble_sequencer;

  logic        clk, reset, start;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [11:0] rom_data;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_a, alu_b, alu_out;
  logic        alu_carry, alu_zero;
  logic [3:0]  out_data;
  logic        out_valid, out_ready, halted;
  logic [4:0]  alu_sum;

  logic [11:0] rom [256];
  int checks = 0;
  int errors = 0;

  int mpc, macc;
  bit mc, mz, mhalt;
  int exp_out[$];

  typedef struct {
    string       name;
    logic [11:0] p0, p1, p2, p3;
    logic [7:0]  exp_pc;
    logic [3:0]  exp_acc;
  } vec_t;
  vec_t vecs[12];

  nibble_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // External ALU: CMP reports a borrow in carry and equality in zero.
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  always_comb begin
    alu_out   = 4'd0;
    alu_carry = 1'b0;
    alu_zero  = 1'b0;
    case (alu_opcode)
      3'd1: begin
        alu_out   = alu_a - alu_b;
        alu_carry = (alu_a < alu_b);
        alu_zero  = (alu_a == alu_b);
      end
      3'd3: begin
        alu_out   = alu_sum[3:0];
        alu_carry = alu_sum[4];
        alu_zero  = (alu_sum[3:0] == 4'd0);
      end
      default: ;
    endcase
  end

  function automatic logic [11:0] ins(input logic [2:0] op, input logic [7:0] opd);
    return {op, 1'b0, opd};
  endfunction

  function automatic bit cond(input int which);
    case (which)
      0: return rom_en;
      1: return out_valid;
      2: return halted;
      default: return (alu_opcode == 3'd3);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = ins(3'd2, 8'd0);
  endtask

  task automatic do_reset();
    start = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_for(input int which, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(which) && n < 100);
    if (!cond(which)) checkOutput(name, 32'(n), 32'd0);
  endtask

  // ISA-level reference: one call executes the instruction at the model pc.
  task automatic model_step();
    logic [11:0] w;
    int op, opd, b, nxt, s;
    w   = rom[mpc];
    op  = int'(w[11:9]);
    opd = int'(w[7:0]);
    b   = opd % 16;
    nxt = (mpc + 1) % 256;
    case (op)
      0: begin exp_out.push_back(macc); mpc = nxt; end
      1: begin mc = (macc < b); mz = (macc == b); mpc = nxt; end
      2: begin macc = b; mpc = nxt; end
      3: begin s = macc + b; mc = (s > 15); macc = s % 16; mz = (macc == 0); mpc = nxt; end
      4: begin macc = 15 - (macc | b); mz = (macc == 0); mc = 1'b0; mpc = nxt; end
      5: begin if (opd == mpc) mhalt = 1'b1; mpc = opd; end
      6: mpc = mc ? opd : nxt;
      default: mpc = mz ? opd : nxt;
    endcase
  endtask

  task automatic applyStimulus();
    for (int v = 0; v < 12; v++) begin
      clear_rom();
      rom[0] = vecs[v].p0;
      rom[1] = vecs[v].p1;
      rom[2] = vecs[v].p2;
      rom[3] = vecs[v].p3;
      do_reset();
      out_ready = 1'b1;
      pulse_start();
      for (int f = 0; f < 5; f++) wait_for(0, {vecs[v].name, "_fetch_timeout"});
      checkOutput({vecs[v].name, "_pc"}, 32'(rom_addr), 32'(vecs[v].exp_pc));
      checkOutput({vecs[v].name, "_acc"}, 32'(alu_a), 32'(vecs[v].exp_acc));
    end
  endtask

  task automatic seq_out_basic();
    int f_at[$];
    int f_addr[$];
    int vc;
    logic [3:0] vd;
    clear_rom();
    rom[0] = ins(3'd2, 8'd5);
    rom[1] = ins(3'd3, 8'd3);
    rom[2] = ins(3'd0, 8'd0);
    rom[3] = ins(3'd6, 8'h40);
    do_reset();
    out_ready = 1'b1;
    pulse_start();
    vc = 0;
    vd = 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rom_en) begin
        f_at.push_back(i);
        f_addr.push_back(int'(rom_addr));
      end
      if (out_valid) begin
        vc++;
        vd = out_data;
      end
    end
    checkOutput("out_valid_cycles", 32'(vc), 32'd1);
    checkOutput("out_data_sum", 32'(vd), 32'd8);
    if (f_at.size() < 5) checkOutput("out_fetch_count", 32'(f_at.size()), 32'd5);
    else begin
      checkOutput("instr_cycles", 32'(f_at[1] - f_at[0]), 32'd3);
      checkOutput("out_instr_cycles", 32'(f_at[3] - f_at[2]), 32'd4);
      checkOutput("jc_not_taken_pc", 32'(f_addr[4]), 32'd4);
    end
  endtask

  task automatic seq_out_stall();
    bit stable;
    clear_rom();
    rom[0] = ins(3'd2, 8'd9);
    rom[1] = ins(3'd0, 8'd0);
    do_reset();
    pulse_start();
    wait_for(1, "stall_valid_timeout");
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(out_valid && out_data == 4'd9 && rom_addr == 8'd1 && !rom_en)) stable = 1'b0;
      @(negedge clk);
    end
    checkOutput("stall_hold", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release", 32'({rom_en, rom_addr, out_valid}), 32'({1'b1, 8'd2, 1'b0}));
    out_ready = 1'b0;
  endtask

  task automatic seq_halt();
    bit fetched;
    clear_rom();
    for (int i = 0; i < 7; i++) rom[i] = ins(3'd2, 8'(i));
    rom[7] = ins(3'd5, 8'd7);
    do_reset();
    pulse_start();
    wait_for(2, "halt7_timeout");
    checkOutput("halt7_state", 32'({halted, rom_addr}), 32'({1'b1, 8'd7}));
    fetched = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rom_en) fetched = 1'b1;
    end
    checkOutput("halt7_no_fetch", 32'(fetched), 32'd0);
    pulse_start();
    checkOutput("restart_after_halt", 32'({halted, rom_en, rom_addr}), 32'({1'b0, 1'b1, 8'd0}));

    clear_rom();
    rom[0]   = ins(3'd5, 8'hFF);
    rom[255] = ins(3'd5, 8'hFF);
    do_reset();
    pulse_start();
    wait_for(2, "haltff_timeout");
    checkOutput("haltff_state", 32'({halted, rom_addr}), 32'({1'b1, 8'hFF}));

    clear_rom();
    rom[0]   = ins(3'd5, 8'hFF);
    rom[255] = ins(3'd2, 8'd6);
    do_reset();
    pulse_start();
    for (int f = 0; f < 3; f++) wait_for(0, "wrap_fetch_timeout");
    checkOutput("pc_wrap", 32'({rom_addr, alu_a}), 32'({8'd0, 4'd6}));
  endtask

  task automatic reset_midway(input int which, input string name);
    bit fetched;
    clear_rom();
    rom[0] = ins(3'd2, 8'd5);
    rom[1] = ins(3'd3, 8'd3);
    rom[2] = ins(3'd0, 8'd0);
    do_reset();
    pulse_start();
    wait_for(which, {name, "_timeout"});
    reset = 1'b1;
    #1;
    checkOutput({name, "_async_reset"},
                32'({rom_en, rom_addr, alu_opcode, alu_a, alu_b, out_valid, out_data, halted}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    fetched = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rom_en) fetched = 1'b1;
    end
    checkOutput({name, "_no_fetch"}, 32'(fetched), 32'd0);
  endtask

  task automatic random_run(input int run);
    int cyc, fetches, opd;
    bit done;
    for (int a = 0; a < 256; a++) begin
      opd = $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) opd = $urandom_range(0, 255);
      rom[a] = ins(3'($urandom_range(0, 7)), 8'(opd));
    end
    do_reset();
    mpc = 0; macc = 0; mc = 1'b0; mz = 1'b0; mhalt = 1'b0;
    exp_out.delete();
    out_ready = 1'b1;
    pulse_start();
    cyc = 0;
    fetches = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (rom_en) begin
        if (mhalt) checkOutput("rnd_fetch_after_halt", 32'(rom_en), 32'd0);
        else begin
          checkOutput("rnd_pc", 32'(rom_addr), 32'(mpc));
          checkOutput("rnd_acc", 32'(alu_a), 32'(macc));
          model_step();
          fetches++;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) checkOutput("rnd_out_extra", 32'(out_valid), 32'd0);
        else checkOutput("rnd_out", 32'(out_data), 32'(exp_out.pop_front()));
      end
      if (mhalt && halted) begin
        checkOutput("rnd_out_drained", 32'(exp_out.size()), 32'd0);
        done = 1'b1;
      end else if (!mhalt && fetches >= 80) begin
        done = 1'b1;
      end else if (cyc >= 800) begin
        $display("[TB] run %0d stopped by cycle bound", run);
        checkOutput("rnd_cycle_bound", 32'(cyc), 32'd0);
        done = 1'b1;
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{"add_carry_jc",     ins(2,0),  ins(2,15), ins(3,1),  ins(6,8'h20), 8'h20, 4'd0};
    vecs[1]  = '{"ld_keeps_zero",    ins(2,15), ins(3,1),  ins(2,7),  ins(7,8'h21), 8'h21, 4'd7};
    vecs[2]  = '{"cmp_eq_jz",        ins(2,0),  ins(2,4),  ins(1,4),  ins(7,8'h10), 8'h10, 4'd4};
    vecs[3]  = '{"cmp_lt_jz",        ins(2,0),  ins(2,4),  ins(1,5),  ins(7,8'h10), 8'h04, 4'd4};
    vecs[4]  = '{"cmp_lt_jc",        ins(2,0),  ins(2,4),  ins(1,5),  ins(6,8'h11), 8'h11, 4'd4};
    vecs[5]  = '{"nor_nonzero",      ins(2,0),  ins(2,5),  ins(4,2),  ins(7,8'h30), 8'h04, 4'd8};
    vecs[6]  = '{"nor_zero",         ins(2,0),  ins(2,0),  ins(4,15), ins(7,8'h30), 8'h30, 4'd0};
    vecs[7]  = '{"nor_clears_carry", ins(2,15), ins(3,1),  ins(4,0),  ins(6,8'h22), 8'h04, 4'd15};
    vecs[8]  = '{"add_wrap_jc",      ins(2,3),  ins(3,4),  ins(3,9),  ins(6,8'h40), 8'h40, 4'd0};
    vecs[9]  = '{"cmp_gt_no_jump",   ins(2,9),  ins(1,3),  ins(6,8'h12), ins(7,8'h13), 8'h04, 4'd9};
    vecs[10] = '{"add_twice_jz",     ins(2,6),  ins(3,5),  ins(3,5),  ins(7,8'h50), 8'h50, 4'd0};
    vecs[11] = '{"operand_low_bits", ins(2,0),  12'h5A3,   ins(3,8'hF1), ins(6,8'h60), 8'h04, 4'd4};

    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    clear_rom();
    #1;
    checkOutput("reset_before_clock",
                32'({rom_en, rom_addr, alu_opcode, alu_a, alu_b, out_valid, out_data, halted}), 32'd0);
    do_reset();
    @(negedge clk);
    checkOutput("reset_idle",
                32'({rom_en, rom_addr, alu_opcode, alu_a, alu_b, out_valid, out_data, halted}), 32'd0);

    applyStimulus();
    seq_out_basic();
    seq_out_stall();
    seq_halt();
    reset_midway(3, "reset_mid_exec_add");
    reset_midway(1, "reset_mid_outwait");
    for (int r = 0; r < 8; r++) random_run(r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
